// File: rtl/arp_pkg.sv
// Shared definitions for the ARP blocks.
//   arp_state_t  - controller FSM states
//   ARP_TYPE_*   - opcode encoding on the arp_tx_type / arp_rx_type wires
//   MAC_BCAST    - destination MAC used for ARP requests
package arp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_WAIT_RESP = 2'd3
  } arp_state_t;

  localparam logic        ARP_TYPE_REQ = 1'b0;
  localparam logic        ARP_TYPE_REP = 1'b1;
  localparam logic [47:0] MAC_BCAST    = 48'hFF_FF_FF_FF_FF_FF;

endpackage

// File: rtl/arp_ctrl.sv
// ARP protocol controller. Answers every received ARP request, resolves a
// target IP on user command (broadcast request, timeout, retry) and keeps
// the learned MAC in a one-entry cache. Sole master of arp_tx_en.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   arp_rx_done/type    received-frame pulse and opcode (0 req, 1 reply)
//   src_mac, src_ip     sender of the received frame
//   arp_tx_en/type      transmit start pulse and opcode
//   des_mac, des_ip     destination of the transmitted frame
//   tx_done             transmitter finished the frame
//   resolve_start/ip    user command and target IP
//   resolve_busy/done/fail  resolve status
//   cache_valid/mac/ip  one-entry ARP cache
//
// Build option: define ARP_CTRL_RETRY_EN to retransmit up to MAX_RETRY
// times on timeout; without it the first timeout fails the resolve.
//
// Handshake: arp_tx_en is a one-cycle start pulse; des_* and arp_tx_type
// are valid with it and held until the one-cycle tx_done pulse. The
// debug view of the FSM is the 'state' signal.
module arp_ctrl
  import arp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 125_000_000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  input  logic        tx_done,
  input  logic        resolve_start,
  input  logic [31:0] resolve_ip,
  output logic        resolve_busy,
  output logic        resolve_done,
  output logic        resolve_fail,
  output logic        cache_valid,
  output logic [47:0] cache_mac,
  output logic [31:0] cache_ip
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arp_state_t state, state_nx, ret_state, ret_nx;

  logic        pend_rep;
  logic [47:0] pend_mac;
  logic [31:0] pend_ip;
  logic [31:0] target_ip;
  logic [CNT_W-1:0] tmo_cnt;

  logic rx_req, rx_rep, rx_match, accept, tmo_hit;
  logic load_rep, load_req, do_fail;

  assign rx_req   = arp_rx_done & (arp_rx_type == ARP_TYPE_REQ);
  assign rx_rep   = arp_rx_done & (arp_rx_type == ARP_TYPE_REP);
  assign rx_match = rx_rep & resolve_busy & (src_ip == target_ip);
  assign accept   = resolve_start & ~resolve_busy;
  // The counter saturates here, so a timeout reached during a reply
  // detour is still seen once the FSM is back in WAIT_RESP.
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

`ifdef ARP_CTRL_RETRY_EN
  localparam logic [7:0] RTY_MAX = 8'(MAX_RETRY);
  logic [7:0] retry_cnt;
  logic       do_retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retry_cnt <= '0;
    else if (accept)   retry_cnt <= '0;
    else if (do_retry) retry_cnt <= retry_cnt + 8'd1;
  end
`else
  // MAX_RETRY has no effect when retries are compiled out.
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  always_comb begin
    state_nx = state;
    ret_nx   = ret_state;
    load_rep = 1'b0;
    load_req = 1'b0;
    do_fail  = 1'b0;
`ifdef ARP_CTRL_RETRY_EN
    do_retry = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // Replies always win over our own request.
        if (pend_rep) begin
          state_nx = ST_SEND;
          ret_nx   = ST_IDLE;
          load_rep = 1'b1;
        end else if (resolve_busy && !rx_match) begin
          state_nx = ST_SEND;
          load_req = 1'b1;
        end
      end
      ST_SEND: state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (arp_tx_type == ARP_TYPE_REQ)
            state_nx = (resolve_busy && !rx_match) ? ST_WAIT_RESP : ST_IDLE;
          else
            state_nx = (ret_state == ST_WAIT_RESP && resolve_busy && !rx_match)
                       ? ST_WAIT_RESP : ST_IDLE;
        end
      end
      ST_WAIT_RESP: begin
        if (pend_rep) begin
          state_nx = ST_SEND;
          ret_nx   = ST_WAIT_RESP;
          load_rep = 1'b1;
        end else if (!resolve_busy || rx_match) begin
          state_nx = ST_IDLE;
        end else if (tmo_hit) begin
`ifdef ARP_CTRL_RETRY_EN
          if (retry_cnt < RTY_MAX) begin
            state_nx = ST_SEND;
            load_req = 1'b1;
            do_retry = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            do_fail  = 1'b1;
          end
`else
          state_nx = ST_IDLE;
          do_fail  = 1'b1;
`endif
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ret_state    <= ST_IDLE;
      pend_rep     <= 1'b0;
      pend_mac     <= '0;
      pend_ip      <= '0;
      target_ip    <= '0;
      tmo_cnt      <= '0;
      arp_tx_en    <= 1'b0;
      arp_tx_type  <= ARP_TYPE_REQ;
      des_mac      <= '0;
      des_ip       <= '0;
      resolve_busy <= 1'b0;
      resolve_done <= 1'b0;
      resolve_fail <= 1'b0;
      cache_valid  <= 1'b0;
      cache_mac    <= '0;
      cache_ip     <= '0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;

      // Latest requester wins; a new request beats the clear of the old one.
      if (rx_req) begin
        pend_rep <= 1'b1;
        pend_mac <= src_mac;
        pend_ip  <= src_ip;
      end else if (load_rep) begin
        pend_rep <= 1'b0;
      end

      arp_tx_en <= load_rep | load_req;
      if (load_rep) begin
        arp_tx_type <= ARP_TYPE_REP;
        des_mac     <= pend_mac;
        des_ip      <= pend_ip;
      end else if (load_req) begin
        arp_tx_type <= ARP_TYPE_REQ;
        des_mac     <= MAC_BCAST;
        des_ip      <= target_ip;
      end

      if (state == ST_WAIT_DONE && tx_done && arp_tx_type == ARP_TYPE_REQ)
        tmo_cnt <= '0;
      else if (resolve_busy && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;

      resolve_done <= rx_match;
      resolve_fail <= do_fail;

      if (accept) begin
        resolve_busy <= 1'b1;
        target_ip    <= resolve_ip;
      end else if (rx_match || do_fail) begin
        resolve_busy <= 1'b0;
      end

      // rx_match needs busy and accept needs !busy, so they never collide.
      if (rx_match) begin
        cache_valid <= 1'b1;
        cache_mac   <= src_mac;
        cache_ip    <= src_ip;
      end else begin
        if (rx_rep && cache_valid && src_ip == cache_ip)
          cache_mac <= src_mac;
        if (accept && resolve_ip != cache_ip)
          cache_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arp_ctrl.sv
`timescale 1ns/1ps
module tb_arp_ctrl;
  import arp_pkg::*;

  localparam int T     = 100;
  localparam int R_CFG = 2;
`ifdef ARP_CTRL_RETRY_EN
  localparam int R_EFF = R_CFG;
`else
  localparam int R_EFF = 0;
`endif
  localparam logic [95:0] NO_FRAME = {16'hFFFF, 80'd0};

  logic        clk, rst_n;
  logic        arp_rx_done, arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        arp_tx_en, arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        tx_done;
  logic        resolve_start;
  logic [31:0] resolve_ip;
  logic        resolve_busy, resolve_done, resolve_fail;
  logic        cache_valid;
  logic [47:0] cache_mac;
  logic [31:0] cache_ip;

  arp_ctrl #(.TIMEOUT_CYC(T), .MAX_RETRY(R_CFG), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
    .src_mac(src_mac), .src_ip(src_ip),
    .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
    .des_mac(des_mac), .des_ip(des_ip), .tx_done(tx_done),
    .resolve_start(resolve_start), .resolve_ip(resolve_ip),
    .resolve_busy(resolve_busy), .resolve_done(resolve_done),
    .resolve_fail(resolve_fail),
    .cache_valid(cache_valid), .cache_mac(cache_mac), .cache_ip(cache_ip)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [95:0] mk_frame(input logic t, input logic [47:0] m, input logic [31:0] i);
    return {15'd0, t, m, i};
  endfunction

  // Reference cache contents, updated from the protocol rules.
  logic        m_cv = 1'b0;
  logic [47:0] m_cm = '0;
  logic [31:0] m_ci = '0;

  // ---------------- transmitter model + frame monitor ----------------
  int tx_count = 0;
  int last_tx_cyc = 0;
  int last_done_cyc = 0;
  bit tx_busy = 1'b0;

  initial begin : tx_model
    logic [95:0] want;
    int len;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (arp_tx_en === 1'b1) begin
        tx_busy = 1'b1;
        last_tx_cyc = cyc;
        tx_count++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : NO_FRAME;
        check("frame", mk_frame(arp_tx_type, des_mac, des_ip), want);
        len = $urandom_range(3, 8);
        repeat (len) @(negedge clk);
        check("frame_hold", mk_frame(arp_tx_type, des_mac, des_ip), want);
        tx_done = 1'b1;
        last_done_cyc = cyc;
        @(negedge clk);
        tx_done = 1'b0;
        tx_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic stim(input bit do_rx, input logic t, input logic [47:0] m, input logic [31:0] ip,
                      input bit do_rs, input logic [31:0] rip, output int c);
    @(posedge clk); #1;
    arp_rx_done = do_rx; arp_rx_type = t; src_mac = m; src_ip = ip;
    resolve_start = do_rs; resolve_ip = rip;
    c = cyc;
    @(posedge clk); #1;
    arp_rx_done = 1'b0; resolve_start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (tx_count < n && k < 400) begin @(posedge clk); k++; end
    check(tag, tx_count, n);
  endtask

  task automatic wait_tx_idle();
    int k = 0;
    @(posedge clk);
    while (tx_busy && k < 400) begin @(posedge clk); k++; end
  endtask

  task automatic wait_idle();
    int k = 0, q = 0;
    while (q < 4 && k < 2000) begin
      @(posedge clk); k++;
      if (!tx_busy && !resolve_busy && !arp_tx_en) q++; else q = 0;
    end
    check("idle_reach", q, 4);
  endtask

  // Next transmit start or resolve failure, whichever comes first.
  task automatic wait_event(input int budget, output int e, output bit was_fail);
    e = -1; was_fail = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (resolve_fail === 1'b1) begin e = cyc; was_fail = 1'b1; break; end
      if (arp_tx_en === 1'b1) begin e = cyc; break; end
    end
  endtask

  task automatic finish_resolve(input logic [31:0] ip, input logic [47:0] m, input string tag);
    int c;
    stim(1'b1, ARP_TYPE_REP, m, ip, 1'b0, 32'd0, c);
    m_cv = 1'b1; m_cm = m; m_ci = ip;
    @(negedge clk);
    check({tag, "_done"}, {resolve_done, resolve_busy}, 2'b10);
    check({tag, "_cache"}, {cache_valid, cache_mac, cache_ip}, {m_cv, m_cm, m_ci});
    @(negedge clk);
    check({tag, "_done_once"}, resolve_done, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int c, base, e, nreq;
    bit f;
    logic [31:0] ip, ip2;
    logic [47:0] mac;

    rst_n = 1'b0;
    arp_rx_done = 1'b0; arp_rx_type = 1'b0; src_mac = '0; src_ip = '0;
    resolve_start = 1'b0; resolve_ip = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {arp_tx_en, arp_tx_type, des_mac, des_ip}, '0);
    check("rst_res", {resolve_busy, resolve_done, resolve_fail}, 3'b000);
    check("rst_cache", {cache_valid, cache_mac, cache_ip}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Incoming request answered two cycles later.
    base = tx_count;
    exp_q.push_back(mk_frame(ARP_TYPE_REP, 48'h00_11_22_33_44_55, 32'hC0A8010B));
    stim(1'b1, ARP_TYPE_REQ, 48'h00_11_22_33_44_55, 32'hC0A8010B, 1'b0, 32'd0, c);
    wait_frames(base + 1, "rep_count");
    check("rep_latency", last_tx_cyc, c + 2);
    wait_idle();

    // Resolve with a matching reply.
    base = tx_count;
    exp_q.push_back(mk_frame(ARP_TYPE_REQ, MAC_BCAST, 32'hC0A8010B));
    stim(1'b0, 1'b0, '0, '0, 1'b1, 32'hC0A8010B, c);
    @(negedge clk);
    check("busy_set", resolve_busy, 1'b1);
    wait_frames(base + 1, "req_count");
    check("req_latency", last_tx_cyc, c + 2);
    wait_tx_idle();
    repeat (5) @(posedge clk);
    finish_resolve(32'hC0A8010B, 48'hAA_BB_CC_DD_EE_01, "res1");
    wait_idle();

    // No replies: retries on schedule, then fail.
    base = tx_count;
    for (int k = 0; k <= R_EFF; k++) exp_q.push_back(mk_frame(ARP_TYPE_REQ, MAC_BCAST, 32'hC0A80163));
    stim(1'b0, 1'b0, '0, '0, 1'b1, 32'hC0A80163, c);
    m_cv = 1'b0;
    @(negedge clk);
    check("cache_inval", cache_valid, m_cv);
    wait_frames(base + 1, "tmo_first");
    nreq = 1;
    for (int k = 0; k <= R_CFG; k++) begin
      wait_event(T + 40, e, f);
      check("tmo_cycle", e, last_done_cyc + T + 1);
      if (f || e < 0) break;
      nreq++;
    end
    check("tmo_fail_seen", f, 1'b1);
    check("tmo_busy_drop", resolve_busy, 1'b0);
    check("tmo_req_count", nreq, R_EFF + 1);
    wait_idle();

    // Reply detour while waiting: timer keeps running.
    base = tx_count;
    exp_q.push_back(mk_frame(ARP_TYPE_REQ, MAC_BCAST, 32'hC0A80164));
    stim(1'b0, 1'b0, '0, '0, 1'b1, 32'hC0A80164, c);
    wait_frames(base + 1, "det_req");
    wait_tx_idle();
    e = last_done_cyc;
    while (cyc < e + 20) @(posedge clk);
    exp_q.push_back(mk_frame(ARP_TYPE_REP, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A80105));
    for (int k = 0; k < R_EFF; k++) exp_q.push_back(mk_frame(ARP_TYPE_REQ, MAC_BCAST, 32'hC0A80164));
    stim(1'b1, ARP_TYPE_REQ, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A80105, 1'b0, 32'd0, c);
    wait_frames(base + 2, "det_rep");
    check("det_rep_latency", last_tx_cyc, c + 2);
    begin
      int m0, e2;
      m0 = e;
      wait_event(T + 40, e2, f);
      check("det_timeout_cycle", e2, m0 + T + 1);
      check("det_timeout_kind", f, (R_EFF == 0));
      while (!f && e2 >= 0) wait_event(T + 40, e2, f);
    end
    wait_idle();
    check("det_frames", tx_count - base, R_EFF + 2);

    // Two requests during a frame in flight: only the latest is answered.
    base = tx_count;
    exp_q.push_back(mk_frame(ARP_TYPE_REP, 48'h02_00_00_00_00_1E, 32'hC0A8011E));
    exp_q.push_back(mk_frame(ARP_TYPE_REP, 48'h02_00_00_00_00_15, 32'hC0A80115));
    stim(1'b1, ARP_TYPE_REQ, 48'h02_00_00_00_00_1E, 32'hC0A8011E, 1'b0, 32'd0, c);
    wait_frames(base + 1, "two_first");
    #1;
    arp_rx_done = 1'b1; arp_rx_type = ARP_TYPE_REQ;
    src_mac = 48'h02_00_00_00_00_14; src_ip = 32'hC0A80114;
    @(posedge clk); #1;
    src_mac = 48'h02_00_00_00_00_15; src_ip = 32'hC0A80115;
    @(posedge clk); #1;
    arp_rx_done = 1'b0;
    wait_idle();
    check("two_frames", tx_count - base, 2);

    // Simultaneous request and resolve_start: reply goes first.
    base = tx_count;
    exp_q.push_back(mk_frame(ARP_TYPE_REP, 48'h02_00_00_00_00_28, 32'hC0A80128));
    exp_q.push_back(mk_frame(ARP_TYPE_REQ, MAC_BCAST, 32'hC0A80150));
    stim(1'b1, ARP_TYPE_REQ, 48'h02_00_00_00_00_28, 32'hC0A80128, 1'b1, 32'hC0A80150, c);
    wait_frames(base + 1, "sim_rep");
    check("sim_rep_latency", last_tx_cyc, c + 2);
    wait_frames(base + 2, "sim_req");
    wait_tx_idle();
    finish_resolve(32'hC0A80150, 48'h02_00_00_00_00_50, "sim");
    wait_idle();

    // Reset while waiting for a response.
    base = tx_count;
    exp_q.push_back(mk_frame(ARP_TYPE_REQ, MAC_BCAST, 32'hC0A8013C));
    stim(1'b0, 1'b0, '0, '0, 1'b1, 32'hC0A8013C, c);
    wait_frames(base + 1, "rst_req");
    wait_tx_idle();
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    m_cv = 1'b0; m_cm = '0; m_ci = '0;
    @(negedge clk);
    check("rst2_tx", {arp_tx_en, arp_tx_type, des_mac, des_ip}, '0);
    check("rst2_res", {resolve_busy, resolve_done, resolve_fail}, 3'b000);
    check("rst2_cache", {cache_valid, cache_mac, cache_ip}, {m_cv, m_cm, m_ci});
    @(posedge clk); #1 rst_n = 1'b1;
    base = tx_count;
    exp_q.push_back(mk_frame(ARP_TYPE_REQ, MAC_BCAST, 32'hC0A8013D));
    stim(1'b0, 1'b0, '0, '0, 1'b1, 32'hC0A8013D, c);
    wait_frames(base + 1, "rst2_req");
    check("rst2_req_latency", last_tx_cyc, c + 2);
    wait_tx_idle();
    finish_resolve(32'hC0A8013D, 48'h02_00_00_00_00_3D, "rst2");
    wait_idle();

    // Randomized traffic against the reference cache and frame queue.
    for (int it = 0; it < 24; it++) begin
      int sc;
      sc  = $urandom_range(0, 3);
      ip  = $urandom;
      ip2 = $urandom;
      mac = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
      base = tx_count;
      case (sc)
        0: begin
          exp_q.push_back(mk_frame(ARP_TYPE_REP, mac, ip));
          stim(1'b1, ARP_TYPE_REQ, mac, ip, 1'b0, 32'd0, c);
          wait_frames(base + 1, "rnd_rep");
          check("rnd_rep_latency", last_tx_cyc, c + 2);
        end
        1: begin
          exp_q.push_back(mk_frame(ARP_TYPE_REQ, MAC_BCAST, ip));
          stim(1'b0, 1'b0, '0, '0, 1'b1, ip, c);
          if (ip != m_ci) m_cv = 1'b0;
          wait_frames(base + 1, "rnd_req");
          check("rnd_req_latency", last_tx_cyc, c + 2);
          // A second command while busy must be ignored.
          stim(1'b0, 1'b0, '0, '0, 1'b1, ip2, c);
          wait_tx_idle();
          repeat ($urandom_range(1, 40)) @(posedge clk);
          finish_resolve(ip, mac, "rnd_res");
        end
        default: begin
          if (sc == 2) ip = m_ci;
          stim(1'b1, ARP_TYPE_REP, mac, ip, 1'b0, 32'd0, c);
          if (m_cv && ip == m_ci) m_cm = mac;
          @(negedge clk);
          check("rnd_cache", {cache_valid, cache_mac, cache_ip}, {m_cv, m_cm, m_ci});
          check("rnd_no_done", resolve_done, 1'b0);
        end
      endcase
      wait_idle();
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
